max7219_update_sched: RTL
=========================

# max7219_update_sched

Controller that sequences every register write to the MAX7219 display driver. After reset it issues the driver's initialisation words. In operation it refreshes the eight digit registers on request, and it pushes brightness and blanking changes. Each 16-bit word goes to the downstream serializer (which drives serial_load/serial_dout/serial_clk) over a valid/ready handshake. The block sits between the clock-time/7-segment encoding logic and the serializer.

## Interface
Parameters:
- SCAN_LIMIT, 3'd7: data written to scan-limit register 0x0B; number of scanned digits minus one.

Ports (reset is synchronous, active-high, single clock domain):
- i_clk  in  1  system clock (~10 MHz)
- i_reset  in  1  synchronous reset, active-high
- i_en  in  1  enable. When low, new requests are ignored and no new word is started; a word already presented completes its handshake.
- i_refresh_stb  in  1  one-cycle request to rewrite all digits
- i_digits  in  64  segment data; digit k = i_digits[8k+7:8k], written to address k+1
- i_brightness  in  4  intensity level
- i_blank  in  1  level; 1 = driver in shutdown (display dark)
- o_word  out  16  {4'h0, addr[3:0], data[7:0]}
- o_word_valid  out  1  o_word is valid
- i_word_ready  in  1  serializer can accept a word this cycle
- o_busy  out  1  high in any state other than IDLE
- o_init_done  out  1  high once the init sequence has completed; low again on reset

## Operation
- Transfer rule: a word transfers on a rising i_clk edge where o_word_valid && i_word_ready.
  - While o_word_valid is high and no transfer has occurred, o_word must not change.
  - o_word_valid must not drop without a transfer, except on reset.
- State INIT: sends 5 words in order, then goes to IDLE and sets o_init_done.
  - 0x0F00 (display test off)
  - 0x0900 (no decode)
  - {0x0B, 5'b0, SCAN_LIMIT}
  - {0x0A, 4'h0, i_brightness}, sampled when the word is loaded
  - 0x0C01 (normal operation), or 0x0C00 if i_blank=1
- Pending flags:
  - refresh_pend is set by i_refresh_stb in any state, including INIT. Multiple requests coalesce into one.
  - bright_pend is set when i_brightness differs from the last value sent.
  - blank_pend is set when i_blank differs from the last value sent.
- IDLE priority when flags are pending: blank_pend, then bright_pend, then refresh_pend. Only one state is entered per IDLE visit.
- SHDN: sends {0x0C, 7'h0, ~i_blank} and clears blank_pend. If i_blank changes during the send, the flag sets again after the transfer.
- INTENS: sends {0x0A, 4'h0, i_brightness}, records the value as last sent, and clears bright_pend.
- DIGITS:
  - On entry, snapshots i_digits into a 64-bit register and clears refresh_pend.
  - Sends addresses 0x1..0x8 in order from the snapshot, using a 3-bit digit index that stops after 7 (no wrap).
  - A refresh strobe arriving during DIGITS sets refresh_pend for a later pass. It does not restart the current pass.
- Each state returns to IDLE after its last transfer.
- i_en low: the block stays in or returns to IDLE after the current word and starts nothing. Pending flags are held.
- Reset, including mid-word: next cycle o_word_valid=0, o_busy=1, o_init_done=0, all flags clear, last-sent registers take the current inputs, state=INIT.

## Timing
- Reset values: o_word=16'h0, o_word_valid=0, o_init_done=0, o_busy=1 (INIT). The first init word is valid in the second cycle after reset deasserts.
- Latency from IDLE: with the flag set at edge N, o_word_valid is high in cycle N+1.
- Back-to-back words: the next word in the same state is valid the cycle after the transfer, with no bubble. Switching states goes through IDLE, costing 1 idle cycle.
- With i_word_ready held high, a full digit pass takes 8 transfer cycles plus 1 entry cycle.
- o_init_done rises in the cycle after the 5th init transfer.

## Test plan
- Reset with i_word_ready=1, i_brightness=4'h8, i_blank=0 -> words 0F00, 0900, 0B07, 0A08, 0C01 in 5 consecutive cycles; o_init_done=1 next cycle.
- i_digits=64'h0807060504030201, refresh strobe -> words 0101, 0202, …, 0808 in address order. Changing i_digits mid-pass must not alter the words sent.
- i_word_ready toggled randomly during a digit pass -> o_word stable while stalled; no word dropped or duplicated (exactly 8 transfers).
- Three refresh strobes during a pass, plus a brightness change to 4'h3 -> after the pass: one 0A03, then exactly one further 8-word pass.
- i_blank 0→1 while idle -> single 0C00. i_blank 1→0 during a digit pass -> 0C01 after the pass finishes.
- Reset asserted with o_word_valid high mid-pass -> o_word_valid=0 next cycle, then a full init sequence restarts.

Source files
------------

// File: rtl/max7219_update_sched.sv
// Sequences MAX7219 register writes (init, shutdown, intensity, digit refresh) over a valid/ready word port.
// First word is valid the cycle after a pending flag is seen in IDLE; o_word is held while i_word_ready is low.
module max7219_update_sched #(
  parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_refresh_stb,
  input  logic [63:0] i_digits,
  input  logic [3:0]  i_brightness,
  input  logic        i_blank,
  output logic [15:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_busy,
  output logic        o_init_done
);

  typedef enum logic [2:0] {INIT, IDLE, SHDN, INTENS, DIGITS} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [63:0] snap;
  logic        refresh_pend, bright_pend, blank_pend;
  logic [3:0]  last_bright;
  logic        last_blank;
  logic        xfer, bright_diff, blank_diff;

  assign xfer        = o_word_valid && i_word_ready;
  assign bright_diff = (i_brightness != last_bright);
  assign blank_diff  = (i_blank != last_blank);

  function automatic logic [15:0] init_word(input logic [2:0] k, input logic [3:0] br,
                                            input logic bl);
    case (k)
      3'd0:    init_word = 16'h0F00;
      3'd1:    init_word = 16'h0900;
      3'd2:    init_word = {8'h0B, 5'b0, SCAN_LIMIT};
      3'd3:    init_word = {8'h0A, 4'h0, br};
      default: init_word = {8'h0C, 7'h0, ~bl};
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= INIT;
      o_word       <= 16'h0;
      o_word_valid <= 1'b0;
      o_busy       <= 1'b1;
      o_init_done  <= 1'b0;
      idx          <= 3'd0;
      snap         <= 64'h0;
      refresh_pend <= 1'b0;
      bright_pend  <= 1'b0;
      blank_pend   <= 1'b0;
      last_bright  <= i_brightness;
      last_blank   <= i_blank;
    end else begin
      // Flags accumulate every cycle; the clears below take precedence when a word is loaded.
      refresh_pend <= refresh_pend | i_refresh_stb;
      bright_pend  <= bright_pend | bright_diff;
      blank_pend   <= blank_pend | blank_diff;

      case (state)
        INIT: begin
          // idx counts words already loaded; the sequence pauses (not aborts) while i_en is low.
          if (!o_word_valid || xfer) begin
            if (idx == 3'd5) begin
              o_word_valid <= 1'b0;
              o_busy       <= 1'b0;
              o_init_done  <= 1'b1;
              state        <= IDLE;
            end else if (i_en) begin
              o_word       <= init_word(idx, i_brightness, i_blank);
              o_word_valid <= 1'b1;
              idx          <= idx + 3'd1;
              if (idx == 3'd3) begin
                last_bright <= i_brightness;
                bright_pend <= 1'b0;
              end
              if (idx == 3'd4) begin
                last_blank <= i_blank;
                blank_pend <= 1'b0;
              end
            end else begin
              o_word_valid <= 1'b0;
            end
          end
        end

        IDLE: begin
          if (i_en) begin
            if (blank_pend) begin
              o_word       <= {8'h0C, 7'h0, ~i_blank};
              o_word_valid <= 1'b1;
              o_busy       <= 1'b1;
              last_blank   <= i_blank;
              blank_pend   <= 1'b0;
              state        <= SHDN;
            end else if (bright_pend) begin
              o_word       <= {8'h0A, 4'h0, i_brightness};
              o_word_valid <= 1'b1;
              o_busy       <= 1'b1;
              last_bright  <= i_brightness;
              bright_pend  <= 1'b0;
              state        <= INTENS;
            end else if (refresh_pend) begin
              snap         <= i_digits;
              o_word       <= {8'h01, i_digits[7:0]};
              o_word_valid <= 1'b1;
              o_busy       <= 1'b1;
              idx          <= 3'd0;
              refresh_pend <= i_refresh_stb;
              state        <= DIGITS;
            end
          end
        end

        SHDN, INTENS: begin
          if (xfer) begin
            o_word_valid <= 1'b0;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end

        DIGITS: begin
          if (xfer) begin
            if (idx == 3'd7 || !i_en) begin
              o_word_valid <= 1'b0;
              o_busy       <= 1'b0;
              state        <= IDLE;
              // A pass cut short by i_en is re-requested so the display is not left partial.
              if (idx != 3'd7) refresh_pend <= 1'b1;
            end else begin
              o_word <= {4'h0, {1'b0, idx} + 4'd2, snap[{idx + 3'd1, 3'b000} +: 8]};
              idx    <= idx + 3'd1;
            end
          end
        end

        default: begin
          o_word_valid <= 1'b0;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
